// File: rtl/logic_updown_counter_mod.sv
// logic_updown_counter_mod
// Parametrised synchronous presettable up/down counter with an arbitrary modulus.
// Successor to the 4-bit 74HC161 model. Stages cascade by driving the next
// stage's ENT from this stage's CO.
// Optional feature: define LOGIC_CNT_OVF_EN to add a sticky, registered OVF
// output. OVF is set on any enabled wrap, and cleared by nCLR or nLOAD.
module logic_updown_counter_mod #(
  parameter int WIDTH  = 4,
  parameter int MODULO = 16
) (
  input  logic             CK,
  input  logic             nCLR,
  input  logic             nLOAD,
  input  logic             ENP,
  input  logic             ENT,
  input  logic             UP,
  input  logic [WIDTH-1:0] DATAIN,
  output logic [WIDTH-1:0] COUNTER,
  output logic             CO
`ifdef LOGIC_CNT_OVF_EN
  ,
  output logic             OVF
`endif
);

  if (WIDTH < 1 || WIDTH > 16) begin : g_bad_width
    $error("logic_updown_counter_mod: WIDTH must be 1..16");
  end
  if (MODULO < 2 || MODULO > (1 << WIDTH)) begin : g_bad_modulo
    $error("logic_updown_counter_mod: MODULO must be 2..2**WIDTH");
  end

  // Terminal value, held one bit wider so that MODULO == 2**WIDTH still fits.
  localparam logic [WIDTH:0] MAX_E = (WIDTH+1)'(MODULO - 1);

  // Clamp a load value into the legal range 0..MODULO-1.
  function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] d);
    logic [WIDTH:0] de;
    de = {1'b0, d};
    if (de > MAX_E) return MAX_E[WIDTH-1:0];
    return d;
  endfunction

  // Modular increment or decrement. The arithmetic is one bit wider and then
  // truncated, so neither the carry nor the borrow can alias.
  function automatic logic [WIDTH-1:0] next_count(input logic [WIDTH-1:0] cur,
                                                  input logic             up);
    logic [WIDTH:0] ce;
    logic [WIDTH:0] r;
    ce = {1'b0, cur};
    if (up) r = (ce == MAX_E) ? '0 : ce + 1'b1;
    else    r = (ce == '0)    ? MAX_E : ce - 1'b1;
    return r[WIDTH-1:0];
  endfunction

  logic [WIDTH-1:0] cnt_p0;
  logic             at_max;
  logic             at_zero;
  logic             term;

  // Count register: clear > load > count > hold.
  always_ff @(posedge CK) begin
    if (!nCLR)             cnt_p0 <= '0;
    else if (!nLOAD)       cnt_p0 <= clamp_load(DATAIN);
    else if (ENP && ENT)   cnt_p0 <= next_count(cnt_p0, UP);
  end

  // Terminal-count detect follows the current direction with no added delay.
  always_comb begin
    at_max  = ({1'b0, cnt_p0} == MAX_E);
    at_zero = (cnt_p0 == '0);
    term    = UP ? at_max : at_zero;
    CO      = ENT & term;
  end

  assign COUNTER = cnt_p0;

`ifdef LOGIC_CNT_OVF_EN
  logic ovf_p0;

  // Sticky wrap flag. Clear and load override a wrap on the same edge.
  always_ff @(posedge CK) begin
    if (!nCLR || !nLOAD)          ovf_p0 <= 1'b0;
    else if (ENP && ENT && term)  ovf_p0 <= 1'b1;
  end

  assign OVF = ovf_p0;
`endif

endmodule

// File: tb/tb_logic_updown_counter_mod.sv
// Testbench for logic_updown_counter_mod (WIDTH=4, MODULO=10, plus a mod-60 cascade).
module tb_logic_updown_counter_mod;

  logic       CK = 1'b0;
  logic       nCLR = 1'b1, nLOAD = 1'b1, ENP = 1'b0, ENT = 1'b0, UP = 1'b1;
  logic [3:0] DATAIN = 4'd0;
  logic [3:0] COUNTER;
  logic       CO;

  // cascade signals
  logic       cs_nCLR = 1'b1, cs_ENP = 1'b0, cs_UP = 1'b1;
  logic [3:0] u_cnt, t_cnt;
  logic       u_co, t_co;

`ifdef LOGIC_CNT_OVF_EN
  logic OVF, u_ovf, t_ovf;
  bit   m_ovf;
`endif

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int m;        // reference count value

  always #5 CK = ~CK;

  logic_updown_counter_mod #(.WIDTH(4), .MODULO(10)) dut (
    .CK(CK), .nCLR(nCLR), .nLOAD(nLOAD), .ENP(ENP), .ENT(ENT), .UP(UP),
    .DATAIN(DATAIN), .COUNTER(COUNTER), .CO(CO)
`ifdef LOGIC_CNT_OVF_EN
    , .OVF(OVF)
`endif
  );

  logic_updown_counter_mod #(.WIDTH(4), .MODULO(10)) u_units (
    .CK(CK), .nCLR(cs_nCLR), .nLOAD(1'b1), .ENP(cs_ENP), .ENT(1'b1), .UP(cs_UP),
    .DATAIN(4'd0), .COUNTER(u_cnt), .CO(u_co)
`ifdef LOGIC_CNT_OVF_EN
    , .OVF(u_ovf)
`endif
  );

  logic_updown_counter_mod #(.WIDTH(4), .MODULO(6)) u_tens (
    .CK(CK), .nCLR(cs_nCLR), .nLOAD(1'b1), .ENP(cs_ENP), .ENT(u_co), .UP(cs_UP),
    .DATAIN(4'd0), .COUNTER(t_cnt), .CO(t_co)
`ifdef LOGIC_CNT_OVF_EN
    , .OVF(t_ovf)
`endif
  );

  // Reference model: the counter is an integer modulo 10.
  function automatic int model_next(int cur, bit nclr, bit nload, bit enp, bit ent,
                                    bit up, int d);
    if (!nclr)          return 0;
    if (!nload)         return (d > 9) ? 9 : d;
    if (enp && ent)     return up ? (cur + 1) % 10 : (cur + 9) % 10;
    return cur;
  endfunction

  function automatic bit model_co(int cur, bit ent, bit up);
    return ent && (up ? (cur == 9) : (cur == 0));
  endfunction

  // One clock edge; the model is advanced with the inputs present at the edge.
  task automatic tick();
`ifdef LOGIC_CNT_OVF_EN
    if (!nCLR || !nLOAD) m_ovf = 1'b0;
    else if (ENP && ENT && model_co(m, 1'b1, UP)) m_ovf = 1'b1;
`endif
    m = model_next(m, nCLR, nLOAD, ENP, ENT, UP, int'(DATAIN));
    @(posedge CK);
    #1;
  endtask

  task automatic chk_state(string name);
    chk_cnt++;
    if (COUNTER !== 4'(m))
      $display("FAIL %s COUNTER got %0d expected %0d", name, COUNTER, m);
    else pass_cnt++;
    chk_cnt++;
    if (CO !== model_co(m, ENT, UP))
      $display("FAIL %s CO got %b expected %b", name, CO, model_co(m, ENT, UP));
    else pass_cnt++;
`ifdef LOGIC_CNT_OVF_EN
    chk_cnt++;
    if (OVF !== m_ovf) $display("FAIL %s OVF got %b expected %b", name, OVF, m_ovf);
    else pass_cnt++;
`endif
  endtask

  task automatic test_reset();
    nCLR = 1'b0; tick(); nCLR = 1'b1;
    chk_state("reset_init");
    nLOAD = 1'b0; DATAIN = 4'd7; tick(); nLOAD = 1'b1;
    chk_state("load7");
    ENP = 1'b1; ENT = 1'b1; UP = 1'b1; nCLR = 1'b0; tick(); nCLR = 1'b1;
    chk_cnt++;
    if (COUNTER !== 4'd0 || CO !== 1'b0)
      $display("FAIL reset_up COUNTER/CO got %0d/%b expected 0/0", COUNTER, CO);
    else pass_cnt++;
    ENP = 1'b0; UP = 1'b0; #1;
    chk_cnt++;
    if (CO !== 1'b1) $display("FAIL reset_down_co got %b expected 1", CO);
    else pass_cnt++;
  endtask

  task automatic test_up_wrap();
    ENP = 1'b1; ENT = 1'b1; UP = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk_state($sformatf("up_wrap_%0d", i));
    end
    chk_cnt++;
    if (COUNTER !== 4'd0) $display("FAIL up_wrap_end got %0d expected 0", COUNTER);
    else pass_cnt++;
  endtask

  task automatic test_down_dir();
    ENP = 1'b0; nLOAD = 1'b0; DATAIN = 4'd2; tick(); nLOAD = 1'b1;
    chk_state("down_load2");
    ENP = 1'b1; ENT = 1'b1; UP = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_state($sformatf("down_%0d", i));
    end
    chk_cnt++;
    if (COUNTER !== 4'd9) $display("FAIL down_to_9 got %0d expected 9", COUNTER);
    else pass_cnt++;
    UP = 1'b1; #1;
    chk_state("dir_change_same_cycle");
    tick();
    chk_state("dir_change_edge");
    chk_cnt++;
    if (COUNTER !== 4'd0 || CO !== 1'b0)
      $display("FAIL dir_up_to_0 got %0d/%b expected 0/0", COUNTER, CO);
    else pass_cnt++;
  endtask

  task automatic test_priority();
    ENP = 1'b1; ENT = 1'b1; UP = 1'b1;
    nCLR = 1'b0; nLOAD = 1'b0; DATAIN = 4'd5; tick(); nCLR = 1'b1;
    chk_state("clr_over_load");
    DATAIN = 4'd12; tick();
    chk_state("load_clamp");
    chk_cnt++;
    if (COUNTER !== 4'd9) $display("FAIL load_clamp_9 got %0d expected 9", COUNTER);
    else pass_cnt++;
    DATAIN = 4'd3; tick(); nLOAD = 1'b1;
    chk_state("load_over_count");
  endtask

  task automatic test_enables();
    ENP = 1'b0; nLOAD = 1'b0; DATAIN = 4'd9; tick(); nLOAD = 1'b1;
    ENT = 1'b1; UP = 1'b1; tick();
    chk_state("enp_low_hold");
    chk_cnt++;
    if (COUNTER !== 4'd9 || CO !== 1'b1)
      $display("FAIL enp_low got %0d/%b expected 9/1", COUNTER, CO);
    else pass_cnt++;
    ENP = 1'b1; ENT = 1'b0; tick();
    chk_state("ent_low_hold");
    chk_cnt++;
    if (COUNTER !== 4'd9 || CO !== 1'b0)
      $display("FAIL ent_low got %0d/%b expected 9/0", COUNTER, CO);
    else pass_cnt++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      nCLR   = ($urandom_range(0, 19) != 0);
      nLOAD  = ($urandom_range(0, 9) != 0);
      ENP    = ($urandom_range(0, 3) != 0);
      ENT    = ($urandom_range(0, 3) != 0);
      UP     = $urandom_range(0, 1);
      DATAIN = 4'($urandom_range(0, 15));
      #1;
      chk_state($sformatf("rand_pre_%0d", i));
      tick();
      chk_state($sformatf("rand_%0d", i));
    end
    nCLR = 1'b1; nLOAD = 1'b1;
  endtask

  task automatic test_cascade();
    int n;
    cs_ENP = 1'b0; cs_UP = 1'b1; cs_nCLR = 1'b0;
    @(posedge CK); #1;
    cs_nCLR = 1'b1; cs_ENP = 1'b1;
    n = 0;
    for (int i = 1; i <= 60; i++) begin
      @(posedge CK); #1;
      n = (n + 1) % 60;
      chk_cnt++;
      if (u_cnt !== 4'(n % 10) || t_cnt !== 4'(n / 10))
        $display("FAIL cascade_up_%0d got %0d%0d expected %0d", i, t_cnt, u_cnt, n);
      else pass_cnt++;
    end
    cs_UP = 1'b0;
    @(posedge CK); #1;
    chk_cnt++;
    if (u_cnt !== 4'd9 || t_cnt !== 4'd5)
      $display("FAIL cascade_down got %0d%0d expected 59", t_cnt, u_cnt);
    else pass_cnt++;
    cs_ENP = 1'b0;
  endtask

  initial begin
    m = 0;
`ifdef LOGIC_CNT_OVF_EN
    m_ovf = 1'b0;
`endif
    #2;
    test_reset();
    test_up_wrap();
    test_down_dir();
    test_priority();
    test_enables();
    test_random();
    test_cascade();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
